// File: rtl/bus_responder_if.sv
// CPU-side bus and external-region handshake seen by bus_responder.
// slave is the responder's view; master is the CPU plus external-glue view.
interface bus_responder_if;
  logic [15:0] AB;
  logic [7:0]  DO;
  logic        WE;
  logic [7:0]  DI;
  logic        RDY;
  logic        ext_req;
  logic        ext_we;
  logic [15:0] ext_addr;
  logic [7:0]  ext_wdata;
  logic        ext_ack;
  logic [7:0]  ext_rdata;
  logic        bus_err;

  modport slave (
    input  AB, DO, WE, ext_ack, ext_rdata,
    output DI, RDY, ext_req, ext_we, ext_addr, ext_wdata, bus_err
  );

  modport master (
    output AB, DO, WE, ext_ack, ext_rdata,
    input  DI, RDY, ext_req, ext_we, ext_addr, ext_wdata, bus_err
  );
endinterface

// File: rtl/bus_responder.sv
// Memory-side responder for the 65C02 address bus: zero-wait internal RAM,
// handshaked external region with timeout, and 8'hFF for unmapped space.
//
// state | meaning
// IDLE  | no external access pending; RAM/unmapped accesses complete at once
// WAIT  | ext_req high, waiting for ext_ack or for the timeout to expire
// DONE  | external access completes this edge (RDY=1), then back to IDLE
module bus_responder #(
  parameter int unsigned RAM_AW    = 12,
  parameter logic [7:0]  EXT_HI    = 8'hD0,
  parameter int unsigned EXT_PAGES = 16,
  parameter int unsigned TIMEOUT   = 15
) (
  input logic             clk,
  input logic             RST,
  bus_responder_if.slave  bus
);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DONE} state_t;

  localparam logic [8:0] EXT_LO  = {1'b0, EXT_HI};
  localparam logic [8:0] EXT_END = 9'(EXT_HI + EXT_PAGES);

  state_t      state, state_nxt;
  logic [7:0]  mem [0:(2**RAM_AW)-1];
  logic [7:0]  di_q;
  logic [7:0]  ext_lat;
  logic [7:0]  timer;
  logic        ext_req_q, ext_we_q, bus_err_q;
  logic [15:0] ext_addr_q;
  logic [7:0]  ext_wdata_q;
  logic        ram_hit, ext_hit;
  logic [8:0]  page;
  logic        start_acc, ack_hit, tmo_hit, rdy;

  // RAM takes priority over the external window when they overlap.
  assign page    = {1'b0, bus.AB[15:8]};
  assign ram_hit = (bus.AB[15:RAM_AW] == '0);
  assign ext_hit = !ram_hit && (page >= EXT_LO) && (page < EXT_END);

  always_comb begin
    state_nxt = state;
    start_acc = 1'b0;
    ack_hit   = 1'b0;
    tmo_hit   = 1'b0;
    rdy       = 1'b1;
    case (state)
      S_IDLE: begin
        if (ext_hit) begin
          rdy       = 1'b0;
          start_acc = 1'b1;
          state_nxt = S_WAIT;
        end
      end
      S_WAIT: begin
        rdy = 1'b0;
        if (bus.ext_ack) begin
          ack_hit   = 1'b1;
          state_nxt = S_DONE;
        end else if (timer == 8'd0) begin
          tmo_hit   = 1'b1;
          state_nxt = S_DONE;
        end
      end
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
    if (RST) rdy = 1'b1;
  end

  // Timer is a down-counter loaded with TIMEOUT-1, so WAIT lasts TIMEOUT cycles.
  always_ff @(posedge clk) begin
    if (RST) begin
      state     <= S_IDLE;
      ext_req_q <= 1'b0;
      ext_we_q  <= 1'b0;
      timer     <= 8'd0;
      bus_err_q <= 1'b0;
      di_q      <= 8'hFF;
    end else begin
      state <= state_nxt;
      if (start_acc) begin
        ext_req_q   <= 1'b1;
        ext_we_q    <= bus.WE;
        ext_addr_q  <= bus.AB;
        ext_wdata_q <= bus.DO;
        timer       <= 8'(TIMEOUT - 1);
      end else if (state == S_WAIT) begin
        if (ack_hit || tmo_hit) begin
          ext_req_q <= 1'b0;
          timer     <= 8'd0;
        end else begin
          timer <= timer - 8'd1;
        end
      end
      if (ack_hit && !ext_we_q) ext_lat <= bus.ext_rdata;
      if (tmo_hit) begin
        ext_lat   <= 8'hFF;
        bus_err_q <= 1'b1;
      end
      // DI only moves when a read completes; writes leave it untouched.
      if (rdy) begin
        if (state == S_DONE) begin
          if (!ext_we_q) di_q <= ext_lat;
        end else if (!bus.WE) begin
          di_q <= ram_hit ? mem[bus.AB[RAM_AW-1:0]] : 8'hFF;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!RST && ram_hit && bus.WE) mem[bus.AB[RAM_AW-1:0]] <= bus.DO;
  end

  assign bus.RDY       = rdy;
  assign bus.DI        = di_q;
  assign bus.ext_req   = ext_req_q;
  assign bus.ext_we    = ext_we_q;
  assign bus.ext_addr  = ext_addr_q;
  assign bus.ext_wdata = ext_wdata_q;
  assign bus.bus_err   = bus_err_q;

endmodule

// File: tb/tb_bus_responder.sv
// Directed bench for bus_responder: RAM, unmapped, external handshake,
// timeout/ack race and reset during WAIT, all with hand-computed expectations.
module tb_bus_responder;
  logic clk;
  logic RST;
  int   n_cmp;
  int   n_bad;
  int   req_cnt;
  int   low_cnt;
  logic [15:0] seen_addr;
  logic        seen_we;
  logic [7:0]  seen_wdata;

  bus_responder_if bif ();

  bus_responder dut (.clk(clk), .RST(RST), .bus(bif));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic park();
    bif.AB = 16'h8000;
    bif.WE = 1'b1;
    bif.DO = 8'h00;
  endtask

  // Runs one external access; ack_at counts WAIT cycles from 1, 0 = never ack.
  task automatic ext_access(input logic [15:0] a, input logic w, input logic [7:0] wd,
                            input int ack_at, input logic [7:0] rd);
    int  wcnt;
    logic r;
    bit  done;
    wcnt    = 0;
    req_cnt = 0;
    low_cnt = 0;
    done    = 1'b0;
    bif.AB = a;
    bif.WE = w;
    bif.DO = wd;
    for (int i = 0; i < 60 && !done; i++) begin
      #1;
      r = bif.RDY;
      if (bif.ext_req) begin
        wcnt++;
        req_cnt++;
        if (wcnt == 1) begin
          seen_addr  = bif.ext_addr;
          seen_we    = bif.ext_we;
          seen_wdata = bif.ext_wdata;
        end
        if (wcnt == ack_at) begin
          bif.ext_ack   = 1'b1;
          bif.ext_rdata = rd;
        end
      end
      if (!r) low_cnt++;
      @(posedge clk);
      #1;
      bif.ext_ack = 1'b0;
      if (r) done = 1'b1;
    end
    if (!done) check("ext_access_bound", 32'd0, 32'd1);
    park();
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    bif.ext_ack   = 1'b0;
    bif.ext_rdata = 8'h00;
    bif.AB = 16'hD000;
    bif.WE = 1'b0;
    bif.DO = 8'h00;
    RST = 1'b1;
    #1;
    check("rst_rdy", 32'(bif.RDY), 32'd1);
    step();
    step();
    park();
    check("rst_di", 32'(bif.DI), 32'hFF);
    check("rst_req", 32'(bif.ext_req), 32'd0);
    check("rst_we", 32'(bif.ext_we), 32'd0);
    check("rst_err", 32'(bif.bus_err), 32'd0);
    RST = 1'b0;
    step();

    // RAM write then immediate read of the same address
    bif.AB = 16'h0123; bif.WE = 1'b1; bif.DO = 8'h5A;
    #1 check("ram_w_rdy", 32'(bif.RDY), 32'd1);
    step();
    bif.WE = 1'b0;
    #1 check("ram_r_rdy", 32'(bif.RDY), 32'd1);
    step();
    park();
    check("ram_r_di", 32'(bif.DI), 32'h5A);

    // top RAM byte, then first unmapped byte above it
    bif.AB = 16'h0FFF; bif.WE = 1'b1; bif.DO = 8'hA5;
    step();
    bif.WE = 1'b0;
    step();
    check("ram_top_di", 32'(bif.DI), 32'hA5);
    bif.AB = 16'h1000;
    #1 check("unm_1000_rdy", 32'(bif.RDY), 32'd1);
    step();
    park();
    check("unm_1000_di", 32'(bif.DI), 32'hFF);
    check("unm_1000_req", 32'(bif.ext_req), 32'd0);

    ext_access(16'hD010, 1'b0, 8'h00, 3, 8'h3C);
    check("rd3_req", 32'(req_cnt), 32'd3);
    check("rd3_low", 32'(low_cnt), 32'd4);
    check("rd3_addr", 32'(seen_addr), 32'hD010);
    check("rd3_we", 32'(seen_we), 32'd0);
    check("rd3_di", 32'(bif.DI), 32'h3C);
    check("rd3_err", 32'(bif.bus_err), 32'd0);

    ext_access(16'hD0FF, 1'b1, 8'h77, 1, 8'h00);
    check("wr1_req", 32'(req_cnt), 32'd1);
    check("wr1_low", 32'(low_cnt), 32'd2);
    check("wr1_we", 32'(seen_we), 32'd1);
    check("wr1_wdata", 32'(seen_wdata), 32'h77);
    check("wr1_di", 32'(bif.DI), 32'h3C);

    // ack on the last WAIT cycle beats the timeout
    ext_access(16'hD300, 1'b0, 8'h00, 15, 8'h42);
    check("race_req", 32'(req_cnt), 32'd15);
    check("race_di", 32'(bif.DI), 32'h42);
    check("race_err", 32'(bif.bus_err), 32'd0);

    ext_access(16'hD200, 1'b0, 8'h00, 0, 8'h00);
    check("tmo_req", 32'(req_cnt), 32'd15);
    check("tmo_low", 32'(low_cnt), 32'd16);
    check("tmo_di", 32'(bif.DI), 32'hFF);
    check("tmo_err", 32'(bif.bus_err), 32'd1);
    check("tmo_req_drop", 32'(bif.ext_req), 32'd0);

    bif.AB = 16'h0123; bif.WE = 1'b0;
    step();
    park();
    check("post_ram_di", 32'(bif.DI), 32'h5A);
    check("post_ram_err", 32'(bif.bus_err), 32'd1);

    ext_access(16'hDF00, 1'b0, 8'h00, 2, 8'h99);
    check("last_pg_req", 32'(req_cnt), 32'd2);
    check("last_pg_di", 32'(bif.DI), 32'h99);
    check("last_pg_err", 32'(bif.bus_err), 32'd1);

    // first byte past the external window is unmapped
    bif.AB = 16'hE000; bif.WE = 1'b0;
    #1 check("unm_e000_rdy", 32'(bif.RDY), 32'd1);
    step();
    park();
    check("unm_e000_di", 32'(bif.DI), 32'hFF);
    check("unm_e000_req", 32'(bif.ext_req), 32'd0);

    ext_access(16'hD001, 1'b0, 8'h00, 1, 8'h24);
    check("pre_unm_di", 32'(bif.DI), 32'h24);
    bif.AB = 16'h8000; bif.WE = 1'b0;
    #1 check("unm_r_rdy", 32'(bif.RDY), 32'd1);
    step();
    check("unm_r_di", 32'(bif.DI), 32'hFF);
    bif.WE = 1'b1; bif.DO = 8'h12;
    #1 check("unm_w_rdy", 32'(bif.RDY), 32'd1);
    step();
    check("unm_w_req", 32'(bif.ext_req), 32'd0);
    check("unm_w_err", 32'(bif.bus_err), 32'd1);

    // reset in the second WAIT cycle of a D000 read, then a late ack
    bif.AB = 16'hD000; bif.WE = 1'b0;
    step();
    check("rstw_req1", 32'(bif.ext_req), 32'd1);
    step();
    check("rstw_req2", 32'(bif.ext_req), 32'd1);
    RST = 1'b1;
    park();
    #1 check("rstw_rdy_in", 32'(bif.RDY), 32'd1);
    step();
    RST = 1'b0;
    check("rstw_req_off", 32'(bif.ext_req), 32'd0);
    #1 check("rstw_rdy", 32'(bif.RDY), 32'd1);
    bif.ext_ack = 1'b1; bif.ext_rdata = 8'h55;
    step();
    bif.ext_ack = 1'b0;
    check("rstw_ack_req", 32'(bif.ext_req), 32'd0);
    check("rstw_ack_err", 32'(bif.bus_err), 32'd0);
    check("rstw_ack_di", 32'(bif.DI), 32'hFF);

    ext_access(16'hD000, 1'b0, 8'h00, 1, 8'h11);
    check("after_rst_req", 32'(req_cnt), 32'd1);
    check("after_rst_di", 32'(bif.DI), 32'h11);
    check("after_rst_err", 32'(bif.bus_err), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end
endmodule

// File: doc/bus_responder.md
Name: bus_responder

Overview:
- Memory-side responder for the microcode 65C02 core's address bus.
- Each cycle it takes the CPU's 16-bit AB, DO and WE, decodes the access into one of three regions (internal RAM, external slow region, unmapped), and returns DI and RDY.
- Internal RAM answers with zero wait states. The external region goes through a req/ack handshake with timeout, holding the CPU via RDY.
- Sits between cpu and top-level memory/peripheral glue.

Parameters:
- RAM_AW, 12, internal RAM address width; RAM occupies 0000 .. 2^RAM_AW-1 (default 0000-0FFF).
- EXT_HI, 8'hD0, first high-address byte of the external region.
- EXT_PAGES, 16, number of 256-byte pages in the external region (default D000-DFFF).
- TIMEOUT, 15, max cycles in WAIT before the access is aborted; range 1..255.

Ports:
- clk  in  1  clock.
- RST  in  1  synchronous reset, active high; one clock; all state updates on posedge clk.
- AB  in  16  CPU address; held stable by CPU while RDY=0.
- DO  in  8  CPU write data; held stable while RDY=0.
- WE  in  1  CPU write enable; held stable while RDY=0.
- DI  out  8  read data to CPU; valid the cycle after a read completes.
- RDY  out  1  combinational; 1 = access on AB completes at this posedge.
- ext_req  out  1  external request, registered.
- ext_we  out  1  external write qualifier, registered, valid while ext_req=1.
- ext_addr  out  16  registered copy of AB, valid while ext_req=1.
- ext_wdata  out  8  registered copy of DO, valid while ext_req=1.
- ext_ack  in  1  external completion, single-cycle pulse.
- ext_rdata  in  8  external read data, sampled when ext_ack=1.
- bus_err  out  1  sticky: set on timeout, cleared only by RST.

Behaviour:
- Decode (combinational on AB):
  - RAM region: AB < 2^RAM_AW.
  - EXT region: EXT_HI <= AB[15:8] < EXT_HI+EXT_PAGES.
  - Otherwise UNMAPPED.
  - If RAM and EXT overlap, RAM wins.
- RAM region:
  - RDY=1.
  - Write: if WE=1 at posedge, mem[AB] <= DO.
  - Read: if WE=0, synchronous read; DI = mem[AB] in the next cycle.
  - Read of an address written in the previous cycle returns the new data.
- UNMAPPED region: RDY=1; reads give DI=8'hFF next cycle; writes are dropped silently, with no error.
- DI source:
  - A registered select (RAM / EXT latch / FF), updated only on completed accesses (RDY=1).
  - DI holds its last value while RDY=0.
- External FSM, states IDLE, WAIT, DONE:
  - IDLE:
    - EXT-region address present → RDY=0.
    - Next cycle: ext_req=1, ext_addr/ext_wdata/ext_we captured from AB/DO/WE, timer cleared → WAIT.
  - WAIT:
    - RDY=0; ext_req stays 1; timer counts each cycle.
    - ext_ack=1 → latch ext_rdata (reads only), ext_req=0 next cycle → DONE.
    - timer reaches TIMEOUT with no ack → latch 8'hFF, set bus_err, ext_req=0 → DONE.
    - ack and expiry in the same cycle: ack wins; no error.
  - DONE:
    - RDY=1 (access completes this edge) → IDLE.
    - DI = latched value in the following cycle.
  - Minimum external access: 3 cycles with RDY low for 2, when ext_ack arrives in the first WAIT cycle.
- ext_ack outside WAIT is ignored.
- Back-to-back EXT accesses are both served; each passes through IDLE, so there is no request merging.
- Reset:
  - While RST=1: RDY=1, no RAM writes.
  - State after reset: ext_req=0, ext_we=0, FSM=IDLE, timer=0, bus_err=0, DI select=FF (DI=8'hFF the cycle after reset).
  - RST during WAIT aborts the request: ext_req=0 next cycle; a late ext_ack is ignored.
  - RAM contents are not reset.

Test Plan:
- Write 8'h5A to 0123, then read 0123 → RDY stays 1 throughout; DI=8'h5A the cycle after the read.
- Read D010, ext_ack with ext_rdata=8'h3C on the 3rd WAIT cycle:
  - ext_req high for exactly 3 cycles, ext_addr=D010, ext_we=0.
  - RDY low 4 cycles; DI=8'h3C after completion; bus_err=0.
- Write 8'h77 to D0FF with an immediate ack → ext_we=1, ext_wdata=8'h77, RDY low 2 cycles; DI unchanged.
- Read D200, no ack, TIMEOUT=15:
  - ext_req high 15 cycles, then drops.
  - DI=8'hFF; bus_err=1 and stays 1 through later good accesses.
- Read 8000 (unmapped) → RDY=1, DI=8'hFF. Write 8000 → no ext_req, bus_err unchanged.
- Assert RST in the 2nd WAIT cycle of a D000 read:
  - ext_req=0 next cycle, FSM IDLE, RDY=1.
  - ext_ack pulsed 1 cycle later has no effect; bus_err=0.
